// File: rtl/gf_mul_pkg.sv
// Shared types and sizing helpers for the digit-serial GF(2^m) multipliers.
package gf_mul_pkg;

    // Controller states of the serial multiplier.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Default field: B-163 / sect163 degree, eight multiplier bits per clock.
    localparam int DEF_DATA_WIDTH = 163;
    localparam int DEF_DIGITAL    = 8;

    // f(x) without its x^163 term for B-163: x^7 + x^6 + x^3 + 1.
    localparam logic [DEF_DATA_WIDTH-1:0] B163_G = 163'hC9;

    // Number of digit steps needed to consume the whole multiplier.
    function automatic int num_digits(input int data_width, input int digital);
        return (data_width + digital - 1) / digital;
    endfunction

    // Counter width able to hold the values 0..n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/gf_lsd_step.sv
// One LSB-first digit step: for each multiplier bit (lowest first) conditionally
// add the running multiplicand into the accumulator, then multiply the
// multiplicand by x and reduce modulo f(x) = x^m + g(x).
module gf_lsd_step #(
    parameter int DATA_WIDTH = 163,
    parameter int DIGITAL    = 8
) (
    input  logic [DIGITAL-1:0]    b_digit,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] g,
    input  logic [DATA_WIDTH-1:0] acc_in,
    output logic [DATA_WIDTH-1:0] acc_out,
    output logic [DATA_WIDTH-1:0] a_out
);

    localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};

    for (genvar i = 0; i < DIGITAL; i++) begin : g_bit
        logic [DATA_WIDTH-1:0] acc_i_s;
        logic [DATA_WIDTH-1:0] a_i_s;
        logic [DATA_WIDTH-1:0] acc_o_s;
        logic [DATA_WIDTH-1:0] a_o_s;

        if (i == 0) begin : g_first
            assign acc_i_s = acc_in;
            assign a_i_s   = a_in;
        end else begin : g_next
            assign acc_i_s = g_bit[i-1].acc_o_s;
            assign a_i_s   = g_bit[i-1].a_o_s;
        end

        assign acc_o_s = acc_i_s ^ (b_digit[i] ? a_i_s : ZERO);
        // x * a: shift left, fold the overflowing x^m term back in as g.
        assign a_o_s   = {a_i_s[DATA_WIDTH-2:0], 1'b0} ^ (a_i_s[DATA_WIDTH-1] ? g : ZERO);
    end

    assign acc_out = g_bit[DIGITAL-1].acc_o_s;
    assign a_out   = g_bit[DIGITAL-1].a_o_s;

endmodule

// File: rtl/gf_mul_lsd_serial.sv
// Digit-serial GF(2^m) polynomial-basis multiplier, multiplier scanned
// least-significant digit first, DIGITAL bits per clock, with a
// start/ready/done handshake. The product is held on c until the next
// accepted operation completes.
module gf_mul_lsd_serial
    import gf_mul_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DIGITAL    = DEF_DIGITAL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] g,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] c
);

    localparam int N  = num_digits(DATA_WIDTH, DIGITAL);
    localparam int CW = cnt_width(N);
    // Multiplier register is padded to a whole number of digits.
    localparam int NB = N * DIGITAL;

    localparam logic [CW-1:0]         CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [DATA_WIDTH-1:0] ZERO_W   = {DATA_WIDTH{1'b0}};
    localparam logic [NB-1:0]         ZERO_B   = {NB{1'b0}};

    state_e                state_r;
    state_e                state_next_s;
    logic [CW-1:0]         cnt_r;
    logic [DATA_WIDTH-1:0] a_r;
    logic [NB-1:0]         b_r;
    logic [NB-1:0]         b_pad_s;
    logic [DATA_WIDTH-1:0] acc_r;
    logic [DATA_WIDTH-1:0] acc_next_s;
    logic [DATA_WIDTH-1:0] a_next_s;
    logic [DATA_WIDTH-1:0] c_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  load_s;
    logic                  step_s;
    logic                  finish_s;

    gf_lsd_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .DIGITAL    (DIGITAL)
    ) u_step (
        .b_digit (b_r[DIGITAL-1:0]),
        .a_in    (a_r),
        .g       (g),
        .acc_in  (acc_r),
        .acc_out (acc_next_s),
        .a_out   (a_next_s)
    );

    // Zero-extend the incoming multiplier to the padded digit length.
    always_comb begin
        b_pad_s                  = ZERO_B;
        b_pad_s[DATA_WIDTH-1:0]  = b;
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                step_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_DONE;
                    finish_s     = 1'b1;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                // Back-to-back start is taken straight from DONE.
                if (start) begin
                    state_next_s = ST_RUN;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered busy/done flags derived from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_RUN);
            done_r  <= finish_s;
        end
    end

    // Operand latch on accepted start, otherwise one digit step per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= ZERO_W;
            b_r   <= ZERO_B;
            acc_r <= ZERO_W;
            cnt_r <= {CW{1'b0}};
        end else if (load_s) begin
            a_r   <= a;
            b_r   <= b_pad_s;
            acc_r <= ZERO_W;
            cnt_r <= {CW{1'b0}};
        end else if (step_s) begin
            a_r   <= a_next_s;
            b_r   <= b_r >> DIGITAL;
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Result register: written only when the last digit step completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_r <= ZERO_W;
        end else if (finish_s) begin
            c_r <= acc_next_s;
        end
    end

    assign c     = c_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign ready = ~busy_r;

endmodule

// File: tb/tb_gf_mul_lsd_serial.sv
// Directed/random bench for gf_mul_lsd_serial (B-163, 8 bits per clock).
// Expected products come from an MSB-first reference multiplier and are
// queued at start, then popped when done is seen.
module tb_gf_mul_lsd_serial;
    import gf_mul_pkg::*;

    localparam int W = 163;
    localparam int D = 8;
    localparam int N = num_digits(W, D);

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] ain;
    logic [W-1:0] bin;
    logic [W-1:0] gin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] c;

    logic [W-1:0] exp_q[$];
    int total;
    int bad;

    gf_mul_lsd_serial #(.DATA_WIDTH(W), .DIGITAL(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (ain),
        .b     (bin),
        .g     (gin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .c     (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: Horner's rule over b from the top bit down.
    function automatic logic [W-1:0] gf_ref(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [W-1:0] f);
        logic [W-1:0] r;
        r = '0;
        for (int i = W - 1; i >= 0; i--) begin
            r = r[W-1] ? ((r << 1) ^ f) : (r << 1);
            if (y[i]) r = r ^ x;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with ready=1; start is sampled on the next edge.
    task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] y);
        ain   = x;
        bin   = y;
        start = 1'b1;
        exp_q.push_back(gf_ref(x, y, gin));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done. poke>=0 pulses start with junk operands and
    // also changes a/b while the DUT is running.
    task automatic wait_done(input int poke, output int lat, output int bcnt,
                             output bit moved, output bit seen);
        logic [W-1:0] c0;
        c0 = c; lat = 0; bcnt = 0; moved = 1'b0; seen = 1'b0;
        if (busy) bcnt++;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == poke) begin
                start = 1'b1; ain = rnd(); bin = rnd();
            end else if (poke >= 0 && lat == poke + 1) begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) bcnt++;
                if (c !== c0) moved = 1'b1;
            end
        end
    endtask

    task automatic check_result(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '0;
        check(tag, c, e);
    endtask

    // Full single operation: start, wait, check latency, busy length, hold and value.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int poke);
        int lat; int bcnt; bit moved; bit seen;
        do_start(x, y);
        wait_done(poke, lat, bcnt, moved, seen);
        check({tag, "_seen"}, W'(seen), W'(1));
        check({tag, "_lat"}, W'(lat), W'(N));
        check({tag, "_busy"}, W'(bcnt), W'(N));
        check({tag, "_held"}, W'(moved), W'(0));
        check_result({tag, "_c"});
        @(posedge clk); #1;
        check({tag, "_pulse"}, W'(done), W'(0));
        check({tag, "_idle"}, W'(ready), W'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat; int bcnt; bit moved; bit seen; int hits;
        logic [W-1:0] x; logic [W-1:0] y;
        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; ain = '0; bin = '0; gin = B163_G;

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("rst_c", c, '0);
        check("rst_ready", W'(ready), W'(1));
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Test 1: 1*1 with latency/busy length
        run_op("t1", W'(1), W'(1), -1);

        // Test 2: x * x^162 = x^163 mod f = g
        x = '0; x[1] = 1'b1;
        y = '0; y[W-1] = 1'b1;
        run_op("t2", x, y, -1);
        check("t2_const", c, W'(163'hC9));

        // Test 3: zero operands and top-bit squaring
        run_op("t3_a0", '0, rnd(), -1);
        run_op("t3_b0", rnd(), '0, -1);
        x = '0; x[W-1] = 1'b1;
        run_op("t3_top", x, x, -1);

        // Test 4: random pairs, with ignored start and operand churn while busy
        for (int i = 0; i < 150; i++) begin
            run_op("t4", rnd(), rnd(), (i % 3 == 0) ? 5 : ((i % 3 == 1) ? N - 1 : -1));
        end

        // Test 5: reset in the middle of a run
        do_start(rnd(), rnd());
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t5_c", c, '0);
        check("t5_busy", W'(busy), W'(0));
        check("t5_ready", W'(ready), W'(1));
        check("t5_done", W'(done), W'(0));
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(posedge clk); #1;
            if (done) hits++;
        end
        check("t5_nodone", W'(hits), W'(0));
        run_op("t5_after", rnd(), rnd(), -1);

        // Test 6: start held high, new operands presented in each DONE cycle
        ain = rnd(); bin = rnd(); start = 1'b1;
        exp_q.push_back(gf_ref(ain, bin, gin));
        @(posedge clk); #1;
        wait_done(-1, lat, bcnt, moved, seen);
        check("t6_first_lat", W'(lat), W'(N));
        check_result("t6_first_c");
        for (int j = 0; j < 4; j++) begin
            ain = rnd(); bin = rnd();
            exp_q.push_back(gf_ref(ain, bin, gin));
            wait_done(-1, lat, bcnt, moved, seen);
            check("t6_seen", W'(seen), W'(1));
            // N non-done cycles separate consecutive pulses.
            check("t6_gap", W'(lat - 1), W'(N));
            check("t6_held", W'(moved), W'(0));
            check_result("t6_c");
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("t6_end_ready", W'(ready), W'(1));
        check("t6_end_done", W'(done), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
